branch_predictor: RTL and testbench

Bimodal branch predictor with a direct-mapped branch target buffer for the 5-stage pipeline. It predicts the next fetch PC in IF, and takes the branch outcome resolved in EX (the comparator's `branch_take`) to detect mispredictions, generate the redirect PC and train its table. It also keeps running branch and misprediction counters for performance debug.

---
 rtl/branch_predictor.sv | 118 +++++++++++
 tb/tb_branch_predictor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with a direct-mapped BTB.
// Predicts next fetch PC in IF, resolves and trains from EX.
module branch_predictor #(
   parameter int ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_next,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic        ex_branch_take,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_target,
   input  logic [31:0] ex_pred_next,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic [31:0] branch_cnt,
   output logic [31:0] mispred_cnt
);

   localparam int IDX = $clog2(ENTRIES);
   localparam int TW  = 30 - IDX;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   logic          val_q [ENTRIES];
   logic [TW-1:0] tag_q [ENTRIES];
   logic [31:0]   tgt_q [ENTRIES];
   logic [1:0]    ctr_q [ENTRIES];

   logic [31:0]    bcnt_q, bcnt_d;
   logic [31:0]    mcnt_q, mcnt_d;
   logic [IDX-1:0] if_idx, ex_idx;
   logic [TW-1:0]  if_tag, ex_tag;
   logic           if_hit, ex_hit;
   logic           upd, take;
   logic [31:0]    actual_next;
   logic [1:0]     ctr_d;

   assign if_idx = if_pc[IDX+1:2];
   assign if_tag = if_pc[31:IDX+2];
   assign ex_idx = ex_pc[IDX+1:2];
   assign ex_tag = ex_pc[31:IDX+2];

   assign if_hit = val_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign ex_hit = val_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

   // IF lookup: taken only on a hit with a taken-leaning counter
   always_comb begin
      pred_taken = if_hit && ctr_q[if_idx][1];
      pred_next  = pred_taken ? tgt_q[if_idx] : if_pc + 32'd4;
   end

   assign upd  = ex_valid && ex_is_branch;
   assign take = ex_is_branch && ex_branch_take;

   // EX resolution: compare real next PC with the one fetched
   always_comb begin
      actual_next = take ? ex_target : ex_pc + 32'd4;
      mispredict  = ex_valid && (actual_next != ex_pred_next);
      redirect_pc = actual_next;
   end

   // Saturating counter step; a fresh allocation starts weakly taken
   always_comb begin
      ctr_d = ctr_q[ex_idx];
      if (!ex_hit) begin
         ctr_d = WT;
      end else if (ex_branch_take) begin
         if (ctr_q[ex_idx] != ST) ctr_d = ctr_q[ex_idx] + 2'b01;
      end else begin
         if (ctr_q[ex_idx] != SNT) ctr_d = ctr_q[ex_idx] - 2'b01;
      end
   end

   // Table write: train on hits, allocate only on taken misses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            val_q[i] <= 1'b0;
            tag_q[i] <= '0;
            tgt_q[i] <= '0;
            ctr_q[i] <= WNT;
         end
      end else if (upd && (ex_hit || ex_branch_take)) begin
         val_q[ex_idx] <= 1'b1;
         tag_q[ex_idx] <= ex_tag;
         ctr_q[ex_idx] <= ctr_d;
         if (ex_branch_take) tgt_q[ex_idx] <= ex_target;
      end
   end

   // Performance counters, wrapping naturally at 32 bits
   always_comb begin
      bcnt_d = bcnt_q + {31'd0, upd};
      mcnt_d = mcnt_q + {31'd0, mispredict};
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt_q <= '0;
         mcnt_q <= '0;
      end else begin
         bcnt_q <= bcnt_d;
         mcnt_q <= mcnt_d;
      end
   end

   assign branch_cnt  = bcnt_q;
   assign mispred_cnt = mcnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed scenarios plus
// randomized traffic against a table-level reference model.
module tb_branch_predictor;

   localparam int ENTRIES = 16;
   localparam int SH = $clog2(ENTRIES) + 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_next;
   logic        ex_valid, ex_is_branch, ex_branch_take;
   logic [31:0] ex_pc, ex_target, ex_pred_next;
   logic        mispredict;
   logic [31:0] redirect_pc, branch_cnt, mispred_cnt;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   branch_predictor #(.ENTRIES(ENTRIES)) dut (
      .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
      .pred_taken(pred_taken), .pred_next(pred_next),
      .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
      .ex_branch_take(ex_branch_take), .ex_pc(ex_pc),
      .ex_target(ex_target), .ex_pred_next(ex_pred_next),
      .mispredict(mispredict), .redirect_pc(redirect_pc),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: one record per slot, keyed by pc / 4 mod ENTRIES
   bit          m_val [ENTRIES];
   int unsigned m_tag [ENTRIES];
   int unsigned m_tgt [ENTRIES];
   int          m_ctr [ENTRIES];
   int unsigned m_bcnt, m_mcnt;

   function automatic int slot(input int unsigned pc);
      return (pc / 4) % ENTRIES;
   endfunction

   function automatic int unsigned tagof(input int unsigned pc);
      return pc >> SH;
   endfunction

   function automatic int unsigned m_next(input int unsigned pc);
      int s = slot(pc);
      if (m_val[s] && m_tag[s] == tagof(pc) && m_ctr[s] >= 2)
         return m_tgt[s];
      return pc + 4;
   endfunction

   function automatic bit m_taken(input int unsigned pc);
      int s = slot(pc);
      return m_val[s] && m_tag[s] == tagof(pc) && m_ctr[s] >= 2;
   endfunction

   function automatic int unsigned m_actual();
      if (ex_is_branch && ex_branch_take) return ex_target;
      return ex_pc + 4;
   endfunction

   function automatic bit m_mis();
      return ex_valid && (m_actual() != ex_pred_next);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_val[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
      m_bcnt = 0; m_mcnt = 0;
   endtask

   // Model state advance, mirroring architectural effects of each edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_reset();
      end else begin
         int s;
         bit hit;
         s = slot(ex_pc);
         hit = m_val[s] && m_tag[s] == tagof(ex_pc);
         if (m_mis()) m_mcnt = m_mcnt + 1;
         if (ex_valid && ex_is_branch) begin
            m_bcnt = m_bcnt + 1;
            if (hit && ex_branch_take) begin
               m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
               m_tgt[s] = ex_target;
            end else if (hit) begin
               m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
            end else if (ex_branch_take) begin
               m_val[s] = 1; m_tag[s] = tagof(ex_pc);
               m_tgt[s] = ex_target; m_ctr[s] = 2;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   // Per-cycle compare against the model on the falling edge
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_pred_taken", {31'd0, pred_taken},
             {31'd0, m_taken(if_pc)});
         chk("m_pred_next", pred_next, m_next(if_pc));
         chk("m_mispredict", {31'd0, mispredict}, {31'd0, m_mis()});
         if (m_mis()) chk("m_redirect", redirect_pc, m_actual());
         chk("m_branch_cnt", branch_cnt, m_bcnt);
         chk("m_mispred_cnt", mispred_cnt, m_mcnt);
      end
   end

   task automatic drive(input logic v, input logic b, input logic t,
                        input logic [31:0] pc, input logic [31:0] tg,
                        input logic [31:0] pn, input logic [31:0] fpc);
      @(posedge clk);
      #1;
      ex_valid = v; ex_is_branch = b; ex_branch_take = t;
      ex_pc = pc; ex_target = tg; ex_pred_next = pn; if_pc = fpc;
   endtask

   task automatic idle(input logic [31:0] fpc);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, fpc);
   endtask

   initial begin
      rst_n = 1'b0;
      ex_valid = 0; ex_is_branch = 0; ex_branch_take = 0;
      ex_pc = 0; ex_target = 0; ex_pred_next = 0; if_pc = 32'h100;
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;

      idle(32'h100);
      #3;
      chk("rst_taken", {31'd0, pred_taken}, 32'd0);
      chk("rst_next", pred_next, 32'h104);
      chk("rst_bcnt", branch_cnt, 32'd0);
      chk("rst_mcnt", mispred_cnt, 32'd0);

      // cold miss taken, lookup of the same index this cycle
      drive(1, 1, 1, 32'h100, 32'h80, 32'h104, 32'h100);
      #3;
      chk("a_mis", {31'd0, mispredict}, 32'd1);
      chk("a_redir", redirect_pc, 32'h80);
      chk("same_cyc_taken", {31'd0, pred_taken}, 32'd0);
      idle(32'h100);
      #3;
      chk("a_next_taken", {31'd0, pred_taken}, 32'd1);
      chk("a_next_pc", pred_next, 32'h80);
      chk("a_mcnt", mispred_cnt, 32'd1);

      drive(1, 1, 1, 32'h100, 32'h80, 32'h80, 32'h100);
      #3 chk("b1_mis", {31'd0, mispredict}, 32'd0);
      drive(1, 1, 1, 32'h100, 32'h80, 32'h80, 32'h100);
      #3 chk("b2_mis", {31'd0, mispredict}, 32'd0);
      drive(1, 1, 0, 32'h100, 32'h80, 32'h80, 32'h100);
      #3;
      chk("c1_mis", {31'd0, mispredict}, 32'd1);
      chk("c1_redir", redirect_pc, 32'h104);
      idle(32'h100);
      #3 chk("c1_next", pred_next, 32'h80);
      drive(1, 1, 0, 32'h100, 32'h80, 32'h80, 32'h100);
      idle(32'h100);
      #3;
      chk("c2_next", pred_next, 32'h104);
      chk("c2_bcnt", branch_cnt, 32'd5);
      chk("c2_mcnt", mispred_cnt, 32'd3);

      // alias 0x140 onto the 0x100 slot
      drive(1, 1, 1, 32'h140, 32'h200, 32'h144, 32'h100);
      idle(32'h100);
      #3 chk("alias_old", pred_next, 32'h104);
      idle(32'h140);
      #3 chk("alias_new", pred_next, 32'h200);

      // asynchronous reset between edges
      idle(32'h140);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_taken", {31'd0, pred_taken}, 32'd0);
      chk("arst_bcnt", branch_cnt, 32'd0);
      chk("arst_mcnt", mispred_cnt, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // stale taken prediction on a non-branch
      drive(1, 0, 0, 32'h100, 32'h0, 32'h80, 32'h100);
      #3;
      chk("nb_mis", {31'd0, mispredict}, 32'd1);
      chk("nb_redir", redirect_pc, 32'h104);
      idle(32'h100);
      #3 chk("nb_bcnt", branch_cnt, 32'd0);

      // randomized traffic over a small PC pool to force hits/aliases
      for (int n = 0; n < 600; n++) begin
         logic [31:0] pc, fpc, tg, pn;
         int r;
         pc  = 32'h1000 + ($urandom_range(0, 3) << SH)
               + ($urandom_range(0, 3) << 2);
         fpc = 32'h1000 + ($urandom_range(0, 3) << SH)
               + ($urandom_range(0, 3) << 2);
         tg  = 32'h2000 + ($urandom_range(0, 3) << 2);
         r   = $urandom_range(0, 9);
         if (r < 6) pn = m_next(pc);
         else if (r < 8) pn = pc + 4;
         else pn = tg;
         drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
               $urandom_range(0, 1) == 1, pc, tg, pn, fpc);
      end

      idle(32'h100);
      @(posedge clk);
      #1 chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, errors);
      $finish;
   end

endmodule
